// File: rtl/intr_timer.sv
// Machine timer: 64-bit mtime/mtimecmp with prescaler, auto-reload and level interrupt; ack one cycle after accept.
// No backpressure: req is only sampled in IDLE, so a request raised during RESP is simply ignored.
module intr_timer #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        timer_intr
);

   typedef enum logic {IDLE, RESP} state_t;

   typedef struct packed {
      logic auto_reload;
      logic enable;
   } ctrl_t;

   localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

   state_t      state;
   ctrl_t       ctrl;
   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic [31:0] period;
   logic [31:0] shadow;
   logic [31:0] rdata_q;
   logic        ack_q;
   logic        intr_q;
   logic [15:0] ps_cnt;

   logic        accept;
   logic        wr;
   logic        tick;
   logic        hit;
   logic [31:0] rd_mux;
   logic [63:0] mtime_nxt;
   logic [63:0] cmp_nxt;

   assign accept = (state == IDLE) && req;
   assign wr     = accept && we;
   assign tick   = ctrl.enable && (ps_cnt == PS_LAST);
   assign hit    = ctrl.enable && (mtime >= mtimecmp);

   always_comb begin
      rd_mux = '0;
      case (addr)
         3'd0:    rd_mux = mtime[31:0];
         3'd1:    rd_mux = shadow;
         3'd2:    rd_mux = mtimecmp[31:0];
         3'd3:    rd_mux = mtimecmp[63:32];
         3'd4:    rd_mux = {30'd0, ctrl};
         3'd5:    rd_mux = period;
         default: rd_mux = '0;
      endcase
   end

   // Bus writes win over the increment / auto-reload and touch only the addressed half.
   always_comb begin
      mtime_nxt = tick ? mtime + 64'd1 : mtime;
      if (wr && addr == 3'd0)
         mtime_nxt = {mtime[63:32], wdata};
      else if (wr && addr == 3'd1)
         mtime_nxt = {wdata, mtime[31:0]};

      cmp_nxt = mtimecmp;
      if (ctrl.auto_reload && hit)
         cmp_nxt = mtimecmp + {32'd0, period};
      if (wr && addr == 3'd2)
         cmp_nxt = {mtimecmp[63:32], wdata};
      else if (wr && addr == 3'd3)
         cmp_nxt = {wdata, mtimecmp[31:0]};
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= IDLE;
         ctrl     <= '0;
         mtime    <= '0;
         mtimecmp <= '1;
         period   <= '0;
         shadow   <= '0;
         rdata_q  <= '0;
         ack_q    <= 1'b0;
         intr_q   <= 1'b0;
         ps_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  state   <= RESP;
                  ack_q   <= 1'b1;
                  rdata_q <= we ? '0 : rd_mux;
                  if (!we && addr == 3'd0)
                     shadow <= mtime[63:32];
               end
            end
            RESP: begin
               state   <= IDLE;
               ack_q   <= 1'b0;
               rdata_q <= '0;
            end
            default: state <= IDLE;
         endcase

         if (ctrl.enable)
            ps_cnt <= tick ? '0 : ps_cnt + 16'd1;

         mtime    <= mtime_nxt;
         mtimecmp <= cmp_nxt;

         if (wr && addr == 3'd4)
            ctrl <= ctrl_t'(wdata[1:0]);
         if (wr && addr == 3'd5)
            period <= wdata;

         intr_q <= hit;
      end
   end

   // Outputs are gated by rstn so they read as reset values from the very first reset cycle,
   // which also suppresses the ack of a transaction caught in RESP.
   assign ack        = ack_q & rstn;
   assign rdata      = ack ? rdata_q : '0;
   assign timer_intr = intr_q & rstn;

endmodule

// File: tb/tb_intr_timer.sv
// Bench for intr_timer (PRESCALE=4): register table, counting/compare, torn read, auto-reload, collisions, wrap, reset abort.
module tb_intr_timer;

   logic        clk;
   logic        rstn;
   logic        req;
   logic        we;
   logic [2:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;
   logic        timer_intr;

   intr_timer #(.PRESCALE(4)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .req        (req),
      .we         (we),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .ack        (ack),
      .timer_intr (timer_intr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        chk;
      logic [31:0] val;
   } sb_t;

   typedef struct {
      logic        w;
      logic [2:0]  a;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   sb_t  sb_q[$];
   vec_t vt[19];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic intr_at_ack;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One bus transaction; the expected read value is queued at issue and popped when ack shows up.
   task automatic bus(input string nm, input logic w, input logic [2:0] a,
                      input logic [31:0] d, input logic [31:0] exp);
      sb_t e;
      sb_t got_e;
      bit  got;
      e.chk = !w;
      e.val = exp;
      sb_q.push_back(e);
      req = 1'b1; we = w; addr = a; wdata = d;
      @(posedge clk);
      #1;
      req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      got = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (ack) begin
            got = 1'b1;
            break;
         end
      end
      check({nm, "_ack_seen"}, 64'(got), 64'd1);
      got_e = sb_q.pop_front();
      if (got) begin
         intr_at_ack = timer_intr;
         if (got_e.chk)
            check(nm, 64'(rdata), 64'(got_e.val));
         @(negedge clk);
         check({nm, "_ack_one_cycle"}, 64'(ack), 64'd0);
         check({nm, "_rdata_idle"}, 64'(rdata), 64'd0);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      bus("write", 1'b1, a, d, 32'd0);
   endtask

   task automatic rd(input string nm, input logic [2:0] a, input logic [31:0] exp);
      bus(nm, 1'b0, a, 32'd0, exp);
   endtask

   task automatic do_reset();
      req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int bad_cycles;
      logic exp_i;

      vt[0]  = '{1'b0, 3'd3, 32'd0, 32'hFFFF_FFFF};
      vt[1]  = '{1'b0, 3'd0, 32'd0, 32'h0};
      vt[2]  = '{1'b0, 3'd1, 32'd0, 32'h0};
      vt[3]  = '{1'b0, 3'd2, 32'd0, 32'hFFFF_FFFF};
      vt[4]  = '{1'b0, 3'd4, 32'd0, 32'h0};
      vt[5]  = '{1'b0, 3'd5, 32'd0, 32'h0};
      vt[6]  = '{1'b0, 3'd6, 32'd0, 32'h0};
      vt[7]  = '{1'b0, 3'd7, 32'd0, 32'h0};
      vt[8]  = '{1'b1, 3'd6, 32'h1234_5678, 32'h0};
      vt[9]  = '{1'b0, 3'd6, 32'd0, 32'h0};
      vt[10] = '{1'b1, 3'd7, 32'hCAFE_F00D, 32'h0};
      vt[11] = '{1'b0, 3'd7, 32'd0, 32'h0};
      vt[12] = '{1'b1, 3'd5, 32'hDEAD_BEEF, 32'h0};
      vt[13] = '{1'b0, 3'd5, 32'd0, 32'hDEAD_BEEF};
      vt[14] = '{1'b1, 3'd4, 32'hFFFF_FFFC, 32'h0};
      vt[15] = '{1'b0, 3'd4, 32'd0, 32'h0};
      vt[16] = '{1'b1, 3'd3, 32'hA5A5_A5A5, 32'h0};
      vt[17] = '{1'b1, 3'd2, 32'h1234_0000, 32'h0};
      vt[18] = '{1'b0, 3'd2, 32'd0, 32'h1234_0000};

      // Reset defaults: outputs quiet during reset even with req held, first req after release accepted.
      rstn = 1'b0; req = 1'b1; we = 1'b0; addr = 3'd3; wdata = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_ack", 64'(ack), 64'd0);
         check("reset_rdata", 64'(rdata), 64'd0);
         check("reset_intr", 64'(timer_intr), 64'd0);
      end
      do_reset();
      for (int i = 0; i < 19; i++)
         bus($sformatf("table%0d", i), vt[i].w, vt[i].a, vt[i].d, vt[i].exp);
      check("table_intr", 64'(timer_intr), 64'd0);
      rd("cmp_hi_after_table", 3'd3, 32'hA5A5_A5A5);

      // Count and compare: mtime reaches 3 twelve clocks after enable.
      do_reset();
      wr(3'd2, 32'd3);
      wr(3'd3, 32'd0);
      wr(3'd4, 32'd1);
      repeat (11) @(negedge clk);
      check("cmp_intr_before", 64'(timer_intr), 64'd0);
      @(negedge clk);
      check("cmp_intr_hit", 64'(timer_intr), 64'd1);
      rd("cmp_mtime_lo", 3'd0, 32'd3);
      wr(3'd2, 32'd1000);
      check("raise_cmp_intr_at_ack", 64'(intr_at_ack), 64'd1);
      check("raise_cmp_intr_fall", 64'(timer_intr), 64'd0);
      wr(3'd2, 32'd0);
      check("lower_cmp_intr", 64'(timer_intr), 64'd1);
      wr(3'd4, 32'd0);
      check("disable_intr_at_ack", 64'(intr_at_ack), 64'd1);
      check("disable_intr_low", 64'(timer_intr), 64'd0);

      // Torn read: the mtime_hi read returns the value shadowed by the mtime_lo read.
      do_reset();
      wr(3'd0, 32'hFFFF_FFFF);
      wr(3'd4, 32'd1);
      rd("torn_lo", 3'd0, 32'hFFFF_FFFF);
      repeat (3) @(negedge clk);
      rd("torn_hi_shadow", 3'd1, 32'd0);
      rd("torn_lo_again", 3'd0, 32'd1);
      rd("torn_hi_live", 3'd1, 32'd1);

      // Auto-reload: hits at mtime 10, 15, 20 give one-cycle pulses.
      do_reset();
      wr(3'd2, 32'd10);
      wr(3'd3, 32'd0);
      wr(3'd5, 32'd5);
      wr(3'd4, 32'd3);
      bad_cycles = 0;
      for (int k = 2; k <= 85; k++) begin
         @(negedge clk);
         exp_i = (k == 41) || (k == 61) || (k == 81);
         if (timer_intr !== exp_i)
            bad_cycles++;
      end
      check("reload_pulse_pattern", 64'(bad_cycles), 64'd0);
      rd("reload_cmp_lo", 3'd2, 32'd25);
      repeat (13) @(negedge clk);
      wr(3'd2, 32'd1000);
      check("reload_hit_intr", 64'(intr_at_ack), 64'd1);
      rd("cmp_write_beats_reload", 3'd2, 32'd1000);
      rd("cmp_hi_after_collision", 3'd3, 32'd0);
      repeat (2) @(negedge clk);
      wr(3'd0, 32'd100);
      rd("mtime_write_beats_inc", 3'd0, 32'd100);
      @(negedge clk);
      wr(3'd0, 32'd500);
      repeat (2) @(negedge clk);
      rd("prescale_unaffected", 3'd0, 32'd501);

      // Wrap: all-ones mtime equals all-ones mtimecmp, then rolls to 0.
      do_reset();
      wr(3'd0, 32'hFFFF_FFFF);
      wr(3'd1, 32'hFFFF_FFFF);
      wr(3'd4, 32'd1);
      check("wrap_disabled_intr", 64'(intr_at_ack), 64'd0);
      check("wrap_equal_intr", 64'(timer_intr), 64'd1);
      repeat (3) @(negedge clk);
      check("wrap_intr_last", 64'(timer_intr), 64'd1);
      @(negedge clk);
      check("wrap_intr_drop", 64'(timer_intr), 64'd0);
      rd("wrap_lo", 3'd0, 32'd0);
      rd("wrap_hi", 3'd1, 32'd0);

      // Reset during RESP aborts the transaction and restores defaults.
      wr(3'd3, 32'd0);
      wr(3'd2, 32'd0);
      check("pre_abort_intr", 64'(timer_intr), 64'd1);
      req = 1'b1; we = 1'b1; addr = 3'd5; wdata = 32'd77;
      @(posedge clk);
      #1;
      req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      rstn = 1'b0;
      @(negedge clk);
      check("abort_ack", 64'(ack), 64'd0);
      check("abort_rdata", 64'(rdata), 64'd0);
      check("abort_intr", 64'(timer_intr), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      rd("abort_period", 3'd5, 32'd0);
      rd("abort_ctrl", 3'd4, 32'd0);
      rd("abort_cmp_hi", 3'd3, 32'hFFFF_FFFF);
      rd("abort_cmp_lo", 3'd2, 32'hFFFF_FFFF);
      rd("abort_mtime_lo", 3'd0, 32'd0);
      check("abort_intr_after", 64'(timer_intr), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
